clk_mon: RTL and testbench
==========================

CLK_MON -- requirements
Module: clk_mon

Interface
REQ-001 SHALL have parameter DIV, default 12: nominal clk_in cycles per div_clk period; even, minimum 4.
REQ-002 SHALL have parameter TOL, default 0: allowed deviation of each phase length from DIV/2, in clk_in cycles.
REQ-003 SHALL have port clk_in  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port div_clk  input  1  divided clock under test; asynchronous to clk_in sampling.
REQ-006 SHALL have port rise  output  1  one-cycle strobe per div_clk rising edge.
REQ-007 SHALL have port fall  output  1  one-cycle strobe per div_clk falling edge.
REQ-008 SHALL have port locked  output  1  high while the measured div_clk matches DIV within TOL.
REQ-009 SHALL have port fault  output  1  high after a locked div_clk deviates or stalls.

Function
REQ-010 SHALL pass div_clk through a two-flop synchronizer, then one edge-detect flop; rise/fall SHALL assert on the third clk_in rising edge after div_clk is first sampled at its new level.
REQ-011 SHALL hold rise and fall high for exactly one clk_in cycle per edge and SHALL never assert both in the same cycle.
REQ-012 SHALL keep a phase counter (width clog2(2*DIV+1)) that loads 1 on every detected edge, increments otherwise, and saturates at 2*DIV.
REQ-013 SHALL treat a phase as good when, at its closing edge, the counter is within [DIV/2-TOL, DIV/2+TOL] inclusive.
REQ-014 SHALL NOT evaluate the first edge after reset or after entering ACQ; that edge only starts a measurement.
REQ-015 SHALL implement states ACQ, LOCK and FAULT; reset state ACQ.
REQ-016 In ACQ: each good phase increments a 2-bit good counter; a bad phase or saturation clears it; the fourth consecutive good phase SHALL move to LOCK.
REQ-017 In LOCK: a bad phase or counter saturation (stall) SHALL move to FAULT in the same cycle it is detected.
REQ-018 In FAULT (macro absent): the next detected edge SHALL move to ACQ with the good counter cleared.
REQ-019 SHALL drive locked = (state == LOCK) and fault = (state == FAULT), both registered, with no additional delay.
REQ-020 SHALL keep generating rise/fall strobes in all states.

Reset
REQ-021 SHALL, while reset is low, force synchronizer flops, edge flop, rise, fall, locked, fault, and the good counter to 0, the phase counter to 0, and the state to ACQ.
REQ-022 SHALL, when reset is asserted mid-phase, discard the partial measurement; after release, reacquisition SHALL require the full REQ-014/REQ-016 sequence.

Configuration
REQ-023 SHALL honour macro CLK_MON_STICKY_FAULT_EN: when defined, FAULT is held until reset and REQ-018 does not apply; when undefined, REQ-018 applies.

Structure
REQ-024 SHALL place the state encoding (ACQ=2'b00, LOCK=2'b01, FAULT=2'b10) and the lock-count constant (4) in shared package clk_pkg.
REQ-025 SHALL instantiate the two-flop synchronizer as sub-module sync2 (reset to 0); all other logic in clk_mon.

Verification
REQ-026 SHALL verify: clk_in 12 MHz, DIV=12, div_clk 1 MHz (6 high/6 low) -> one rise and one fall every 12 cycles; locked rises at the fourth good phase closing edge after the first edge; fault stays 0.
REQ-027 SHALL verify: locked, then one div_clk phase stretched to 9 cycles -> fault=1 and locked=0 on the edge closing that phase; the next edge returns to ACQ, and locked returns after four further good phases.
REQ-028 SHALL verify: locked, then div_clk held constant -> fault=1 exactly 24 clk_in cycles after the last edge; rise/fall stay 0 while stalled.
REQ-029 SHALL verify: with CLK_MON_STICKY_FAULT_EN defined, repeat REQ-027 -> fault stays 1 and locked stays 0 through 20 good periods until reset is pulsed low.
REQ-030 SHALL verify: TOL=1, phases alternating 5/7 cycles -> locks; a 4-cycle phase -> FAULT.
REQ-031 SHALL verify: reset pulsed low mid-phase while locked -> all outputs 0 within the reset; relock after release takes exactly four good phases after the first edge.

Source files
------------

// File: rtl/clk_pkg.sv
// Shared definitions for the divided-clock monitor: FSM encoding and lock criteria.
package clk_pkg;

  typedef enum logic [1:0] {
    ACQ   = 2'b00,
    LOCK  = 2'b01,
    FAULT = 2'b10
  } state_t;

  // Consecutive good phases required in ACQ before declaring lock.
  localparam int LOCK_CNT = 4;

  // Clamp the lower tolerance bound so an oversized TOL cannot wrap below zero.
  function automatic int win_lo(input int div, input int tol);
    return (div / 2 > tol) ? (div / 2 - tol) : 0;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk_in domain.
module sync2 (
  input  logic clk_in,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the pre-edge value of its source.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_mon.sv
// Monitors a divided clock: edge strobes, per-phase length checks and an ACQ/LOCK/FAULT tracker.
// Build option: define CLK_MON_STICKY_FAULT_EN to hold FAULT until reset.
module clk_mon #(
  parameter int DIV = 12,
  parameter int TOL = 0
) (
  input  logic clk_in,
  input  logic reset,
  input  logic div_clk,
  output logic rise,
  output logic fall,
  output logic locked,
  output logic fault
);

  import clk_pkg::*;

  localparam int            CW  = $clog2(2 * DIV + 1);
  localparam logic [CW-1:0] SAT = CW'(2 * DIV);
  localparam logic [CW-1:0] LO  = CW'(win_lo(DIV, TOL));
  localparam logic [CW-1:0] HI  = CW'(DIV / 2 + TOL);

  logic          sync_q;
  logic          edge_q;
  logic          det;
  logic          armed;
  logic [CW-1:0] phase_cnt;
  logic          in_win;
  logic          phase_ok;
  logic          phase_bad;
  logic          stall;
  logic [1:0]    good_q, good_d;
  state_t        state_q, state_d;

  sync2 u_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .d      (div_clk),
    .q      (sync_q)
  );

  // det marks the cycle before the strobe; strobe, counter load and FSM move share one edge.
  assign det = sync_q ^ edge_q;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      edge_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      edge_q <= sync_q;
      rise   <= sync_q & ~edge_q;
      fall   <= ~sync_q & edge_q;
    end
  end

  // The counter reads 1 just after an edge, so at the closing edge it equals the phase length.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      phase_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      if (det) begin
        phase_cnt <= CW'(1);
        armed     <= 1'b1;
      end else if (phase_cnt != SAT) begin
        phase_cnt <= phase_cnt + CW'(1);
      end
    end
  end

  // The first edge after reset has no opening edge, so it only arms the measurement.
  assign in_win    = (phase_cnt >= LO) && (phase_cnt <= HI);
  assign phase_ok  = det && armed && in_win;
  assign phase_bad = det && armed && !in_win;
  assign stall     = !det && (phase_cnt == SAT);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= ACQ;
      good_q  <= 2'd0;
      locked  <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      locked  <= (state_d == LOCK);
      fault   <= (state_d == FAULT);
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      ACQ: begin
        if (phase_bad || stall) begin
          good_d = 2'd0;
        end else if (phase_ok) begin
          if (good_q == 2'(LOCK_CNT - 1)) begin
            state_d = LOCK;
            good_d  = 2'd0;
          end else begin
            good_d = good_q + 2'd1;
          end
        end
      end
      LOCK: begin
        if (phase_bad || stall) begin
          state_d = FAULT;
        end
      end
      FAULT: begin
`ifdef CLK_MON_STICKY_FAULT_EN
        state_d = FAULT;
`else
        // The recovering edge also opens the first measurement of the new acquisition.
        if (det) begin
          state_d = ACQ;
          good_d  = 2'd0;
        end
`endif
      end
      default: begin
        state_d = ACQ;
        good_d  = 2'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_clk_mon.sv
// Directed bench for clk_mon: lock, stretched phase, stall, tolerance window and reset recovery.
// One clk_in period is 10 time units; only cycle ratios matter to the monitor.
module tb_clk_mon;

  logic clk_in  = 1'b0;
  logic reset   = 1'b0;
  logic div_clk = 1'b0;
  logic div_t   = 1'b0;
  logic rise, fall, locked, fault;
  logic rise_t, fall_t, locked_t, fault_t;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  clk_mon #(.DIV(12), .TOL(0)) u_dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .div_clk (div_clk),
    .rise    (rise),
    .fall    (fall),
    .locked  (locked),
    .fault   (fault)
  );

  clk_mon #(.DIV(12), .TOL(1)) u_tol (
    .clk_in  (clk_in),
    .reset   (reset),
    .div_clk (div_t),
    .rise    (rise_t),
    .fall    (fall_t),
    .locked  (locked_t),
    .fault   (fault_t)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Observer: samples 2 units after each rising edge and logs strobe and status events.
  int   cyc = 0, edge_total = 0, lock_cyc = -1, fault_cyc = -1, lock_rises = 0;
  int   both_cnt = 0, wide_cnt = 0, last_rise = -1, last_fall = -1, rise_per = 0, fall_per = 0;
  int   edge_log [1024];
  logic rise_p = 1'b0, fall_p = 1'b0, locked_p = 1'b0, fault_p = 1'b0;

  always @(posedge clk_in) begin
    #2;
    cyc++;
    if ((rise || fall) && edge_total < 1024) begin
      edge_log[edge_total] = cyc;
      edge_total++;
    end
    if (rise) begin
      if (last_rise >= 0) rise_per = cyc - last_rise;
      last_rise = cyc;
    end
    if (fall) begin
      if (last_fall >= 0) fall_per = cyc - last_fall;
      last_fall = cyc;
    end
    if ((rise && fall) || (rise_t && fall_t)) both_cnt++;
    if ((rise && rise_p) || (fall && fall_p)) wide_cnt++;
    if (locked && !locked_p) begin
      lock_cyc = cyc;
      lock_rises++;
    end
    if (fault && !fault_p) fault_cyc = cyc;
    rise_p   = rise;
    fall_p   = fall;
    locked_p = locked;
    fault_p  = fault;
  end

  // Toggle the selected divided clock at a falling clk_in edge and hold it n cycles.
  task automatic phase(input bit sel, input int n);
    if (sel) div_t   = ~div_t;
    else     div_clk = ~div_clk;
    repeat (n) @(negedge clk_in);
  endtask

  // Fresh acquisition: edge E0 opens, E1..E4 close good phases, lock lands on E4.
  task automatic relock(input string tag);
    int e0;
    e0 = edge_total;
    phase(0, 6);
    check({tag, "_fault_clear"}, fault, 0);
    repeat (3) phase(0, 6);
    check({tag, "_unlocked_after_3"}, locked, 0);
    phase(0, 6);
    check({tag, "_locked"}, locked, 1);
    check({tag, "_lock_edge"}, lock_cyc, edge_log[e0 + 4]);
  endtask

  // Reset asserted in the middle of a low phase so no spurious edge follows release.
  task automatic pulse_reset(input string tag);
    if (div_clk) phase(0, 6);
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    repeat (3) @(negedge clk_in);
    check({tag, "_outs_in_reset"}, {rise, fall, locked, fault}, 4'b0000);
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    check({tag, "_locked_after_release"}, locked, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, e0, es, lr;

    repeat (4) @(negedge clk_in);
    check("por_outs", {rise, fall, locked, fault}, 4'b0000);
    reset = 1'b1;
    repeat (3) @(negedge clk_in);

    // Nominal 6/6 clock: latency, lock timing, periods.
    c0 = cyc;
    e0 = edge_total;
    relock("nominal");
    check("rise_latency", edge_log[e0], c0 + 3);
    es = edge_total;
    repeat (8) phase(0, 6);
    check("nominal_edge_count", edge_total - es, 8);
    check("rise_period", rise_per, 12);
    check("fall_period", fall_per, 12);
    check("nominal_fault", fault, 0);
    check("nominal_still_locked", locked, 1);

    // One phase stretched to 9 cycles.
    phase(0, 9);
    phase(0, 6);
    check("stretch_fault", fault, 1);
    check("stretch_locked", locked, 0);
    check("stretch_fault_edge", fault_cyc, edge_log[edge_total - 1]);
`ifdef CLK_MON_STICKY_FAULT_EN
    lr = lock_rises;
    repeat (40) phase(0, 6);
    check("sticky_fault", fault, 1);
    check("sticky_locked", locked, 0);
    check("sticky_no_relock", lock_rises, lr);
    pulse_reset("sticky_reset");
    relock("sticky_recover");
`else
    relock("stretch_recover");
`endif

    // Stall: div_clk frozen after its last edge.
    phase(0, 6);
    es = edge_total;
    repeat (30) @(negedge clk_in);
    check("stall_no_strobe", edge_total, es);
    check("stall_fault", fault, 1);
    check("stall_locked", locked, 0);
    check("stall_delay", fault_cyc - edge_log[es - 1], 24);
`ifdef CLK_MON_STICKY_FAULT_EN
    pulse_reset("stall_reset");
`endif
    relock("stall_recover");

    // Reset pulsed mid-phase while locked.
    repeat (2) phase(0, 6);
    check("pre_reset_locked", locked, 1);
    pulse_reset("midphase");
    relock("reset_recover");

    // TOL=1 instance: 5/7 alternation locks, a 4-cycle phase faults.
    repeat (3) begin
      phase(1, 5);
      phase(1, 7);
    end
    check("tol_locked", locked_t, 1);
    check("tol_no_fault", fault_t, 0);
    phase(1, 4);
    phase(1, 6);
    check("tol_short_fault", fault_t, 1);
    check("tol_short_locked", locked_t, 0);

    check("never_both_strobes", both_cnt, 0);
    check("strobes_one_cycle", wide_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
